// File: rtl/seq_mon_pkg.sv
// Shared types and constants for the 1101 match monitor.
// Holds the FSM state encoding and default widths.
package seq_mon_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
    localparam logic [WIN_W_DEF-1:0] WIN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with hard reset, soft clear and load-zero.
// Priority: reset/clear, then load-zero, then increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load0,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_q;

    // Count up, sticking at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_load0) begin
            r_q <= '0;
        end else if (i_inc && (r_q != MAX)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/seq_match_monitor.sv
// Windowed match counter and sticky alarm fed by the 1101 detector.
// Also tracks lifetime matches and the gap between the last two.
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_z,
    input  logic             i_clr,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [CNT_W-1:0] i_thresh,
    output logic [CNT_W-1:0] o_total_cnt,
    output logic [CNT_W-1:0] o_win_cnt,
    output logic [CNT_W-1:0] o_last_win_cnt,
    output logic             o_win_done,
    output logic [WIN_W-1:0] o_last_gap,
    output logic             o_gap_valid,
    output logic             o_alarm
);

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [WIN_W-1:0] W_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [WIN_W-1:0] r_win_len_q;
    logic [CNT_W-1:0] r_last_win_cnt;
    logic             r_win_done;
    logic [WIN_W-1:0] r_last_gap;
    logic             r_gap_valid;
    logic             r_armed;

    logic [CNT_W-1:0] w_total_cnt;
    logic [CNT_W-1:0] w_win_cnt;
    logic [WIN_W-1:0] w_gap_ctr;
    logic [WIN_W-1:0] w_win_pos;

    logic             w_match;
    logic             w_start;
    logic             w_active;
    logic             w_cnt_match;
    logic             w_close;
    logic [CNT_W-1:0] w_final;
    logic             w_alarm_hit;
    logic [WIN_W-1:0] w_gap_next;
    logic             w_alarm;

    // A zero latched length parks the window logic (only reachable in ALARM).
    assign w_match     = i_en && i_z;
    assign w_start     = i_en && (r_state == IDLE) && (i_win_len != '0);
    assign w_active    = i_en && (r_state != IDLE) && (r_win_len_q != '0);
    assign w_cnt_match = w_active && i_z;
    assign w_close     = w_active
                         && (w_win_pos == r_win_len_q - WIN_W'(1));

    assign w_final = (w_cnt_match && (w_win_cnt != C_MAX))
                     ? w_win_cnt + CNT_W'(1) : w_win_cnt;
    assign w_alarm_hit = (i_thresh != '0) && (w_final >= i_thresh);

    assign w_gap_next = (w_gap_ctr == W_MAX)
                        ? w_gap_ctr : w_gap_ctr + WIN_W'(1);

    sat_counter #(.W(CNT_W)) u_total (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_load0 (1'b0),
        .i_inc   (w_cnt_match),
        .o_q     (w_total_cnt)
    );

    sat_counter #(.W(CNT_W)) u_win_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_load0 (w_close),
        .i_inc   (w_cnt_match),
        .o_q     (w_win_cnt)
    );

    sat_counter #(.W(WIN_W)) u_gap (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_load0 (w_match),
        .i_inc   (i_en && r_armed),
        .o_q     (w_gap_ctr)
    );

    sat_counter #(.W(WIN_W)) u_win_pos (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_load0 (w_close || w_start),
        .i_inc   (w_active),
        .o_q     (w_win_pos)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: windows close into ALARM, IDLE or RUN.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_close) begin
                    if (w_alarm_hit) begin
                        w_next = ALARM;
                    end else if (i_win_len == '0) begin
                        w_next = IDLE;
                    end
                end
            end
            ALARM: begin
                w_next = ALARM;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode: alarm follows the registered state.
    always_comb begin
        w_alarm = 1'b0;
        if (r_state == ALARM) begin
            w_alarm = 1'b1;
        end
    end

    // Window length latch, closed-window result and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_win_len_q    <= '0;
            r_last_win_cnt <= '0;
            r_win_done     <= 1'b0;
        end else begin
            r_win_done <= w_close;
            if (w_start || w_close) begin
                r_win_len_q <= i_win_len;
            end
            if (w_close) begin
                r_last_win_cnt <= w_final;
            end
        end
    end

    // Gap capture: first match only arms, later ones record the gap.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_armed     <= 1'b0;
            r_gap_valid <= 1'b0;
            r_last_gap  <= '0;
        end else if (w_match) begin
            r_armed <= 1'b1;
            if (r_armed) begin
                r_last_gap  <= w_gap_next;
                r_gap_valid <= 1'b1;
            end
        end
    end

    assign o_total_cnt    = w_total_cnt;
    assign o_win_cnt      = w_win_cnt;
    assign o_last_win_cnt = r_last_win_cnt;
    assign o_win_done     = r_win_done;
    assign o_last_gap     = r_last_gap;
    assign o_gap_valid    = r_gap_valid;
    assign o_alarm        = w_alarm;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_seq_match_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       z = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] win_len = 8'd0;
    logic [7:0] thresh = 8'd0;

    logic [7:0] total_cnt;
    logic [7:0] win_cnt;
    logic [7:0] last_win_cnt;
    logic       win_done;
    logic [7:0] last_gap;
    logic       gap_valid;
    logic       alarm;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 counting, 2 counting with alarm
    int m_mode, m_len, m_pos, m_wcnt, m_total, m_last;
    int m_done, m_gap, m_lgap, m_gval, m_seen;

    always #5 clk = ~clk;

    seq_match_monitor dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_z            (z),
        .i_clr          (clr),
        .i_win_len      (win_len),
        .i_thresh       (thresh),
        .o_total_cnt    (total_cnt),
        .o_win_cnt      (win_cnt),
        .o_last_win_cnt (last_win_cnt),
        .o_win_done     (win_done),
        .o_last_gap     (last_gap),
        .o_gap_valid    (gap_valid),
        .o_alarm        (alarm)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_pos = 0; m_wcnt = 0;
        m_total = 0; m_last = 0; m_done = 0; m_gap = 0;
        m_lgap = 0; m_gval = 0; m_seen = 0;
    endtask

    task automatic model_edge();
        int wl, th;
        wl = int'(win_len);
        th = int'(thresh);
        if (rst || clr) begin
            model_reset();
        end else if (!en) begin
            m_done = 0;
        end else begin
            m_done = 0;
            if (z) begin
                if (m_seen != 0) begin
                    m_lgap = sat(m_gap + 1);
                    m_gval = 1;
                end
                m_seen = 1;
                m_gap = 0;
            end else if (m_seen != 0) begin
                m_gap = sat(m_gap + 1);
            end
            if (m_mode == 0) begin
                if (wl != 0) begin
                    m_mode = 1;
                    m_len = wl;
                    m_pos = 0;
                end
            end else if (m_len != 0) begin
                if (z) begin
                    m_wcnt = sat(m_wcnt + 1);
                    m_total = sat(m_total + 1);
                end
                if (m_pos == m_len - 1) begin
                    m_last = m_wcnt;
                    m_wcnt = 0;
                    m_pos = 0;
                    m_done = 1;
                    if (th != 0 && m_last >= th) m_mode = 2;
                    m_len = wl;
                    if (wl == 0 && m_mode == 1) m_mode = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("total_cnt", int'(total_cnt), m_total);
        chk("win_cnt", int'(win_cnt), m_wcnt);
        chk("last_win_cnt", int'(last_win_cnt), m_last);
        chk("win_done", int'(win_done), m_done);
        chk("last_gap", int'(last_gap), m_lgap);
        chk("gap_valid", int'(gap_valid), m_gval);
        chk("alarm", int'(alarm), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic soft_clear();
        clr = 1'b1;
        z = 1'b0;
        step();
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        step();
        step();
        chk("reset_total", int'(total_cnt), 0);
        chk("reset_alarm", int'(alarm), 0);
        rst = 1'b0;

        // window of 8, matches at positions 3 and 6, threshold 2
        win_len = 8'd8; thresh = 8'd2; en = 1'b1;
        step();
        for (int p = 0; p < 8; p++) begin
            z = (p == 3 || p == 6);
            step();
        end
        z = 1'b0;
        chk("t1_done", int'(win_done), 1);
        chk("t1_last", int'(last_win_cnt), 2);
        chk("t1_alarm", int'(alarm), 1);
        chk("t1_total", int'(total_cnt), 2);
        chk("t1_gap", int'(last_gap), 3);
        chk("t1_gval", int'(gap_valid), 1);
        step();
        chk("t1_done_pulse", int'(win_done), 0);

        // one match per window, threshold never reached
        soft_clear();
        win_len = 8'd4; thresh = 8'd3;
        step();
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 4; p++) begin
                z = (p == 1);
                step();
            end
            chk("t2_done", int'(win_done), 1);
            chk("t2_last", int'(last_win_cnt), 1);
        end
        z = 1'b0;
        chk("t2_total", int'(total_cnt), 3);
        chk("t2_alarm", int'(alarm), 0);

        // match on the closing edge, then saturation
        soft_clear();
        win_len = 8'd4; thresh = 8'd0;
        step();
        for (int p = 0; p < 4; p++) begin
            z = (p == 3);
            step();
        end
        chk("t3_last", int'(last_win_cnt), 1);
        chk("t3_wcnt", int'(win_cnt), 0);
        z = 1'b1;
        for (int i = 0; i < 300; i++) step();
        z = 1'b0;
        chk("t3_sat", int'(total_cnt), 255);
        chk("t3_gap", int'(last_gap), 1);
        chk("t3_alarm", int'(alarm), 0);

        // enable gap with z high, then clear with a coincident match
        soft_clear();
        win_len = 8'd8;
        step();
        for (int i = 0; i < 3; i++) step();
        en = 1'b0; z = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t4_frozen", int'(total_cnt), 0);
        en = 1'b1; z = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t4_len_kept", int'(win_done), 1);
        z = 1'b1;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0; z = 1'b0;
        chk("t4_clr_total", int'(total_cnt), 0);
        chk("t4_clr_gval", int'(gap_valid), 0);

        // window length change mid-window, then zero length
        win_len = 8'd8; thresh = 8'd0;
        step();
        for (int i = 0; i < 2; i++) step();
        win_len = 8'd3;
        for (int i = 0; i < 20; i++) begin
            z = ($urandom_range(0, 2) == 0);
            step();
        end
        win_len = 8'd0;
        for (int i = 0; i < 6; i++) step();
        z = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t5_idle_wcnt", int'(win_cnt), 0);
        z = 1'b0;

        // reset from ALARM, then length-1 windows
        soft_clear();
        win_len = 8'd2; thresh = 8'd1;
        step();
        z = 1'b1;
        for (int i = 0; i < 4; i++) step();
        z = 1'b0;
        chk("t6_alarm", int'(alarm), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_alarm", int'(alarm), 0);
        chk("t6_rst_total", int'(total_cnt), 0);
        chk("t6_rst_last", int'(last_win_cnt), 0);
        win_len = 8'd1; thresh = 8'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_done_hi", int'(win_done), 1);
        end

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            z = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0)
                win_len = 8'($urandom_range(0, 10));
            if ($urandom_range(0, 49) == 0)
                thresh = 8'($urandom_range(0, 5));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_monitor.md
Name: seq_match_monitor

Overview:
- Downstream consumer of the overlapping "1101" Mealy detector's match output z.
- Counts matches in fixed-length observation windows of bit-clocks.
- Raises a sticky alarm when any window's match count reaches a programmable threshold.
- Also keeps a saturating lifetime match count and the bit-clock gap between the last two matches, for the status/debug path.

Parameters:
- CNT_W, 8, width of match counters and threshold.
- WIN_W, 8, width of window length, window position and gap counters.

Ports:
- clk  in  1  bit clock; same clock as the detector.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit-clock enable; when low, all state is frozen and z is ignored.
- z  in  1  detector match output, sampled only at the rising clk edge.
- clr  in  1  synchronous soft clear of counters, alarm and FSM.
- win_len  in  WIN_W  window length in enabled cycles; 0 = monitor disabled.
- thresh  in  CNT_W  alarm threshold; 0 = alarm never fires.
- total_cnt  out  CNT_W  lifetime match count, saturating at all-ones.
- win_cnt  out  CNT_W  matches so far in the current window, saturating.
- last_win_cnt  out  CNT_W  final count of the most recently closed window.
- win_done  out  1  one-cycle pulse after the edge that closed a window.
- last_gap  out  WIN_W  enabled cycles between the previous two matches, saturating.
- gap_valid  out  1  high once two matches have been seen since reset or clr.
- alarm  out  1  sticky; cleared only by clr or rst.

Behaviour:
- All outputs are registered. Reset and clr values are 0 for every output; the FSM goes to IDLE.
- Priority at each edge: rst > clr > en. A match coinciding with clr is dropped.
- Match definition: z==1 at a rising edge with en==1. A Mealy glitch between edges is never counted.
- FSM states: IDLE, RUN, ALARM.
- IDLE -> RUN when en==1 and win_len!=0.
  - At that edge, latch win_len into win_len_q and set win_pos=0.
  - A match on that edge is not counted; counting starts at the next enabled edge.
- RUN and ALARM are identical except for the alarm output. On each enabled edge:
  - win_pos increments.
  - On a match, win_cnt and total_cnt increment, saturating at 2^CNT_W-1.
- Window close: the enabled edge where win_pos==win_len_q-1.
  - A match on the closing edge belongs to the closing window.
  - last_win_cnt <= final count including that match; win_cnt <= 0; win_pos <= 0.
  - win_len is re-latched, so changes take effect only at window boundaries.
  - win_done is high in the following cycle only.
  - If final count >= thresh and thresh!=0, the FSM goes RUN -> ALARM and alarm goes high at the same edge as win_done.
- win_len_q==1: every enabled edge closes a window and win_done stays high continuously.
- If win_len==0 at a re-latch, the FSM returns to IDLE; counters hold, win_cnt is already 0.
- ALARM exits only via clr (-> IDLE) or rst. Windows keep running while in ALARM.
- Gap counter:
  - Increments on every enabled edge, saturating at 2^WIN_W-1.
  - On a match: last_gap <= gap_ctr+1 (saturated), gap_ctr <= 0.
  - gap_valid sets on the second match after rst/clr; last_gap is meaningful only when gap_valid==1.
  - The first match only zeroes gap_ctr.
  - The gap counter runs in IDLE as well, but only after the first match.
- Minimum legal gap from the overlapping detector is 3 (stream 1101101). The block does not check this.
- en low mid-window: win_pos, counters and FSM hold; the window resumes on the next enabled edge.

Decomposition:
- Package seq_mon_pkg holds:
  - state enum {IDLE, RUN, ALARM};
  - default CNT_W and WIN_W constants;
  - a saturating-max helper constant per width.
- One sub-module, sat_counter, parameterised by width with inc, clr and load-zero inputs. It is instantiated for total_cnt, win_cnt, gap_ctr and win_pos (win_pos never saturates in practice).

Test Plan:
- rst high 2 cycles, then win_len=8, thresh=2, en=1, z pulses at window cycles 3 and 6 -> win_done pulses after cycle 7, last_win_cnt=2, alarm=1 at the same edge, total_cnt=2, last_gap=3, gap_valid=1.
- win_len=4, thresh=3, one match per window for 3 windows -> last_win_cnt=1 each window, alarm stays 0, total_cnt=3, win_done pulses every 4 cycles.
- Match on the closing edge (win_len=4, z high at pos 3) -> last_win_cnt=1 and the new window's win_cnt=0; z held high for 300 enabled cycles -> total_cnt saturates at 255 and last_gap=1.
- en toggled low for 5 cycles mid-window with z=1 during the low period -> no counts and window length unchanged; clr asserted together with a match -> all outputs 0, FSM IDLE, match dropped.
- thresh=0 with many matches -> alarm never asserts; win_len changed mid-window from 8 to 3 -> current window still lasts 8 and the next lasts 3; win_len=0 at a boundary -> returns to IDLE.
- rst asserted while in ALARM with counters non-zero -> every output 0 at the next edge; with win_len=1 -> win_done stays high continuously.
